// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with forwarding muxes and load-use hazard detection
module id_ex_operand_stage #(
    parameter int WIDTH = 32,
    parameter int RA    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_rd1,
    input  logic [WIDTH-1:0] id_rd2,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [RA-1:0]    id_rs,
    input  logic [RA-1:0]    id_rt,
    input  logic [RA-1:0]    id_rd,
    input  logic [2:0]       id_alu_control,
    input  logic             id_alu_src,
    input  logic             id_reg_dst,
    input  logic             id_reg_write,
    input  logic             id_mem_to_reg,
    input  logic             id_mem_write,
    input  logic             exmem_reg_write,
    input  logic [RA-1:0]    exmem_write_reg,
    input  logic [WIDTH-1:0] exmem_alu_result,
    input  logic             memwb_reg_write,
    input  logic [RA-1:0]    memwb_write_reg,
    input  logic [WIDTH-1:0] memwb_result,
    output logic [WIDTH-1:0] src_a,
    output logic [WIDTH-1:0] src_b,
    output logic [2:0]       ALU_control,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [RA-1:0]    ex_write_reg,
    output logic             ex_valid,
    output logic             ex_reg_write,
    output logic             ex_mem_to_reg,
    output logic             ex_mem_write,
    output logic             hazard_stall
);

    logic             valid_q, reg_write_q, mem_to_reg_q, mem_write_q, alu_src_q;
    logic [RA-1:0]    rs_q, rt_q, write_reg_q;
    logic [WIDTH-1:0] rd1_q, rd2_q, imm_q;
    logic [2:0]       alu_control_q;

    logic             load_bubble;
    logic [WIDTH-1:0] rd1_d, rd2_d;
    logic [WIDTH-1:0] fwd_rs, fwd_rt;

    // Writeback happening on the capture edge would otherwise be missed by the stale regfile read.
    always_comb begin
        rd1_d = id_rd1;
        rd2_d = id_rd2;
        if (memwb_reg_write && (memwb_write_reg != '0) && (memwb_write_reg == id_rs))
            rd1_d = memwb_result;
        if (memwb_reg_write && (memwb_write_reg != '0) && (memwb_write_reg == id_rt))
            rd2_d = memwb_result;
    end

    assign hazard_stall = valid_q & mem_to_reg_q & (write_reg_q != '0) & id_valid
                        & ((write_reg_q == id_rs) | (write_reg_q == id_rt));
    assign load_bubble  = flush | hazard_stall | ~id_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q       <= 1'b0;
            rs_q          <= '0;
            rt_q          <= '0;
            write_reg_q   <= '0;
            rd1_q         <= '0;
            rd2_q         <= '0;
            imm_q         <= '0;
            alu_control_q <= 3'b000;
            alu_src_q     <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            mem_write_q   <= 1'b0;
        end else if (!stall) begin
            if (load_bubble) begin
                valid_q       <= 1'b0;
                rs_q          <= '0;
                rt_q          <= '0;
                write_reg_q   <= '0;
                rd1_q         <= '0;
                rd2_q         <= '0;
                imm_q         <= '0;
                alu_control_q <= 3'b000;
                alu_src_q     <= 1'b0;
                reg_write_q   <= 1'b0;
                mem_to_reg_q  <= 1'b0;
                mem_write_q   <= 1'b0;
            end else begin
                valid_q       <= 1'b1;
                rs_q          <= id_rs;
                rt_q          <= id_rt;
                write_reg_q   <= id_reg_dst ? id_rd : id_rt;
                rd1_q         <= rd1_d;
                rd2_q         <= rd2_d;
                imm_q         <= id_imm;
                alu_control_q <= id_alu_control;
                alu_src_q     <= id_alu_src;
                reg_write_q   <= id_reg_write;
                mem_to_reg_q  <= id_mem_to_reg;
                mem_write_q   <= id_mem_write;
            end
        end
    end

    // EX/MEM is the younger producer, so it wins over MEM/WB; $0 is never forwarded.
    always_comb begin
        fwd_rs = rd1_q;
        if (exmem_reg_write && (exmem_write_reg != '0) && (exmem_write_reg == rs_q))
            fwd_rs = exmem_alu_result;
        else if (memwb_reg_write && (memwb_write_reg != '0) && (memwb_write_reg == rs_q))
            fwd_rs = memwb_result;

        fwd_rt = rd2_q;
        if (exmem_reg_write && (exmem_write_reg != '0) && (exmem_write_reg == rt_q))
            fwd_rt = exmem_alu_result;
        else if (memwb_reg_write && (memwb_write_reg != '0) && (memwb_write_reg == rt_q))
            fwd_rt = memwb_result;
    end

    assign src_a         = fwd_rs;
    assign src_b         = alu_src_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ALU_control   = alu_control_q;
    assign ex_write_reg  = write_reg_q;
    assign ex_valid      = valid_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_to_reg = mem_to_reg_q;
    assign ex_mem_write  = mem_write_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - scoreboard bench for the ID/EX operand stage
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [31:0] id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [2:0]  id_alu_control;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_to_reg, id_mem_write;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_write_reg, memwb_write_reg;
    logic [31:0] exmem_alu_result, memwb_result;
    logic [31:0] src_a, src_b, ex_store_data;
    logic [2:0]  ALU_control;
    logic [4:0]  ex_write_reg;
    logic        ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, hazard_stall;

    typedef struct packed {
        logic        v, rw, mtr, mw;
        logic [4:0]  wr;
        logic [2:0]  alu;
        logic [31:0] a, b, st;
    } exp_t;

    exp_t sb[$];
    exp_t e, o;
    int   n_chk = 0;
    int   n_fail = 0;

    id_ex_operand_stage #(.WIDTH(32), .RA(5)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_control(id_alu_control), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
        .exmem_reg_write(exmem_reg_write), .exmem_write_reg(exmem_write_reg),
        .exmem_alu_result(exmem_alu_result),
        .memwb_reg_write(memwb_reg_write), .memwb_write_reg(memwb_write_reg),
        .memwb_result(memwb_result),
        .src_a(src_a), .src_b(src_b), .ALU_control(ALU_control), .ex_store_data(ex_store_data),
        .ex_write_reg(ex_write_reg), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write), .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    function automatic exp_t obs();
        exp_t r;
        r.v = ex_valid; r.rw = ex_reg_write; r.mtr = ex_mem_to_reg; r.mw = ex_mem_write;
        r.wr = ex_write_reg; r.alu = ALU_control;
        r.a = src_a; r.b = src_b; r.st = ex_store_data;
        return r;
    endfunction

    function automatic exp_t mk(logic v, logic rw, logic mtr, logic mw, logic [4:0] wr,
                                logic [2:0] alu, logic [31:0] a, logic [31:0] b, logic [31:0] st);
        exp_t r;
        r.v = v; r.rw = rw; r.mtr = mtr; r.mw = mw; r.wr = wr; r.alu = alu;
        r.a = a; r.b = b; r.st = st;
        return r;
    endfunction

    task automatic set_id(logic v, logic [31:0] rd1, logic [31:0] rd2, logic [31:0] imm,
                          logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [2:0] alu,
                          logic asrc, logic rdst, logic rw, logic mtr, logic mw);
        id_valid = v; id_rd1 = rd1; id_rd2 = rd2; id_imm = imm;
        id_rs = rs; id_rt = rt; id_rd = rd; id_alu_control = alu;
        id_alu_src = asrc; id_reg_dst = rdst; id_reg_write = rw;
        id_mem_to_reg = mtr; id_mem_write = mw;
    endtask

    task automatic set_fwd(logic erw, logic [4:0] ewr, logic [31:0] eres,
                           logic mrw, logic [4:0] mwr, logic [31:0] mres);
        exmem_reg_write = erw; exmem_write_reg = ewr; exmem_alu_result = eres;
        memwb_reg_write = mrw; memwb_write_reg = mwr; memwb_result = mres;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b1; flush = 1'b1;
        set_id(1, 32'h1111, 32'h2222, 32'h3333, 5'd1, 5'd2, 5'd3, 3'b111, 1, 1, 1, 1, 1);
        set_fwd(1, 5'd7, 32'hAAAA, 1, 5'd8, 32'hBBBB);
        #3;
        sb.push_back(mk(0, 0, 0, 0, 5'd0, 3'b000, 32'd0, 32'd0, 32'd0));
        e = sb.pop_front(); o = obs(); n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", o, e); end
        n_chk++;
        if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %b expected 0", hazard_stall); end
        tick();
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        set_fwd(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        set_id(1, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 3'b010, 0, 1, 1, 0, 0);
        sb.push_back(mk(1, 1, 0, 0, 5'd3, 3'b010, 32'd5, 32'd7, 32'd7));
        tick();
        e = sb.pop_front(); o = obs(); n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL first_capture: got %h expected %h", o, e); end
    endtask

    task automatic test_forward_priority();
        set_id(1, 32'h111, 32'h222, 32'd0, 5'd3, 5'd3, 5'd4, 3'b110, 0, 1, 1, 0, 0);
        set_fwd(1, 5'd3, 32'h10, 0, 5'd0, 32'd0);
        sb.push_back(mk(1, 1, 0, 0, 5'd4, 3'b110, 32'h10, 32'h10, 32'h10));
        tick();
        e = sb.pop_front(); o = obs(); n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL exmem_forward: got %h expected %h", o, e); end
        set_fwd(1, 5'd3, 32'h10, 1, 5'd3, 32'h20);
        sb.push_back(mk(1, 1, 0, 0, 5'd4, 3'b110, 32'h10, 32'h10, 32'h10));
        #1;
        e = sb.pop_front(); o = obs(); n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL exmem_priority: got %h expected %h", o, e); end
        set_fwd(0, 5'd3, 32'h10, 1, 5'd3, 32'h20);
        sb.push_back(mk(1, 1, 0, 0, 5'd4, 3'b110, 32'h20, 32'h20, 32'h20));
        #1;
        e = sb.pop_front(); o = obs(); n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL memwb_forward: got %h expected %h", o, e); end
        set_fwd(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        sb.push_back(mk(1, 1, 0, 0, 5'd4, 3'b110, 32'h111, 32'h222, 32'h222));
        #1;
        e = sb.pop_front(); o = obs(); n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL no_forward: got %h expected %h", o, e); end
    endtask

    task automatic test_load_use();
        set_id(1, 32'h40, 32'h0, 32'd4, 5'd1, 5'd2, 5'd9, 3'b010, 1, 0, 1, 1, 0);
        sb.push_back(mk(1, 1, 1, 0, 5'd2, 3'b010, 32'h40, 32'd4, 32'h0));
        tick();
        e = sb.pop_front(); o = obs(); n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL lw_capture: got %h expected %h", o, e); end
        set_id(1, 32'h999, 32'h1, 32'd0, 5'd2, 5'd1, 5'd5, 3'b010, 0, 1, 1, 0, 0);
        #1;
        n_chk++;
        if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL hazard_raise: got %b expected 1", hazard_stall); end
        sb.push_back(mk(0, 0, 0, 0, 5'd0, 3'b000, 32'd0, 32'd0, 32'd0));
        tick();
        e = sb.pop_front(); o = obs(); n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL bubble: got %h expected %h", o, e); end
        n_chk++;
        if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL hazard_one_cycle: got %b expected 0", hazard_stall); end
        set_fwd(0, 5'd0, 32'd0, 1, 5'd2, 32'h77);
        sb.push_back(mk(1, 1, 0, 0, 5'd5, 3'b010, 32'h77, 32'h1, 32'h1));
        tick();
        e = sb.pop_front(); o = obs(); n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL dependent_memwb: got %h expected %h", o, e); end
        set_fwd(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        sb.push_back(mk(1, 1, 0, 0, 5'd5, 3'b010, 32'h77, 32'h1, 32'h1));
        #1;
        e = sb.pop_front(); o = obs(); n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL capture_bypass: got %h expected %h", o, e); end
        n_chk++;
        if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL hazard_after: got %b expected 0", hazard_stall); end
    endtask

    task automatic test_zero_reg();
        set_id(1, 32'h5A, 32'h5B, 32'd0, 5'd0, 5'd0, 5'd6, 3'b001, 0, 1, 1, 0, 0);
        set_fwd(1, 5'd0, 32'hFFFF, 1, 5'd0, 32'h33);
        sb.push_back(mk(1, 1, 0, 0, 5'd6, 3'b001, 32'h5A, 32'h5B, 32'h5B));
        tick();
        e = sb.pop_front(); o = obs(); n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL reg0_not_forwarded: got %h expected %h", o, e); end
    endtask

    task automatic test_imm_store();
        set_id(1, 32'h100, 32'h5, 32'hFFFF_FFF8, 5'd1, 5'd9, 5'd0, 3'b010, 1, 0, 0, 0, 1);
        set_fwd(1, 5'd9, 32'hAB, 0, 5'd0, 32'd0);
        sb.push_back(mk(1, 0, 0, 1, 5'd9, 3'b010, 32'h100, 32'hFFFF_FFF8, 32'hAB));
        tick();
        e = sb.pop_front(); o = obs(); n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL imm_and_store_fwd: got %h expected %h", o, e); end
        set_fwd(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    task automatic test_stall_flush();
        set_id(1, 32'hA, 32'hB, 32'd0, 5'd6, 5'd7, 5'd8, 3'b000, 0, 0, 0, 0, 1);
        sb.push_back(mk(1, 0, 0, 1, 5'd7, 3'b000, 32'hA, 32'hB, 32'hB));
        tick();
        e = sb.pop_front(); o = obs(); n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL pre_stall: got %h expected %h", o, e); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom),
                   3'($urandom), 1'($urandom), 1'($urandom), 1, 0, 0);
            sb.push_back(mk(1, 0, 0, 1, 5'd7, 3'b000, 32'hA, 32'hB, 32'hB));
            tick();
            e = sb.pop_front(); o = obs(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, o, e); end
        end
        flush = 1'b1;
        sb.push_back(mk(1, 0, 0, 1, 5'd7, 3'b000, 32'hA, 32'hB, 32'hB));
        tick();
        e = sb.pop_front(); o = obs(); n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL stall_beats_flush: got %h expected %h", o, e); end
        stall = 1'b0;
        sb.push_back(mk(0, 0, 0, 0, 5'd0, 3'b000, 32'd0, 32'd0, 32'd0));
        tick();
        e = sb.pop_front(); o = obs(); n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL flush_bubble: got %h expected %h", o, e); end
        flush = 1'b0;
        id_valid = 1'b0;
        sb.push_back(mk(0, 0, 0, 0, 5'd0, 3'b000, 32'd0, 32'd0, 32'd0));
        tick();
        e = sb.pop_front(); o = obs(); n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL invalid_bubble: got %h expected %h", o, e); end
    endtask

    task automatic test_reset_mid_stall();
        set_id(1, 32'h3, 32'h4, 32'd0, 5'd10, 5'd11, 5'd12, 3'b111, 0, 1, 1, 0, 0);
        sb.push_back(mk(1, 1, 0, 0, 5'd12, 3'b111, 32'h3, 32'h4, 32'h4));
        tick();
        e = sb.pop_front(); o = obs(); n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL slt_capture: got %h expected %h", o, e); end
        stall = 1'b1; flush = 1'b1;
        #2 reset = 1'b1;
        #1;
        sb.push_back(mk(0, 0, 0, 0, 5'd0, 3'b000, 32'd0, 32'd0, 32'd0));
        e = sb.pop_front(); o = obs(); n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL async_reset: got %h expected %h", o, e); end
        tick();
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        sb.push_back(mk(1, 1, 0, 0, 5'd12, 3'b111, 32'h3, 32'h4, 32'h4));
        tick();
        e = sb.pop_front(); o = obs(); n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL capture_after_reset: got %h expected %h", o, e); end
    endtask

    initial begin
        test_reset();
        test_forward_priority();
        test_load_use();
        test_zero_reg();
        test_imm_store();
        test_stall_flush();
        test_reset_mid_stall();
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline stage of the five-stage MIPS core, directly upstream of the ALU. It registers decoded operands and control on each clock and resolves data hazards. It drives the ALU's `src_a`, `src_b` and `ALU_control` through EX/MEM and MEM/WB forwarding muxes and the ALUSrc immediate mux. It also detects load-use hazards and inserts bubbles.

## Interface
Parameters:
- `WIDTH`, 32: datapath width.
- `RA`, 5: register address width.

Ports:
- `clk`, in, 1: rising-edge clock; the only clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `stall`, in, 1: global hold from the memory system; freezes this stage.
- `flush`, in, 1: replace the captured instruction with a bubble (branch/jump redirect).
- `id_valid`, in, 1: ID-stage instruction valid.
- `id_rd1`, `id_rd2`, in, WIDTH: register file read data for rs and rt.
- `id_imm`, in, WIDTH: sign-extended immediate.
- `id_rs`, `id_rt`, `id_rd`, in, RA: register addresses.
- `id_alu_control`, in, 3: ALU operation (010 add, 110 sub, 000 and, 001 or, 111 slt).
- `id_alu_src`, `id_reg_dst`, `id_reg_write`, `id_mem_to_reg`, `id_mem_write`, in, 1 each: decoded control.
- `exmem_reg_write`, in, 1; `exmem_write_reg`, in, RA; `exmem_alu_result`, in, WIDTH: EX/MEM forwarding source.
- `memwb_reg_write`, in, 1; `memwb_write_reg`, in, RA; `memwb_result`, in, WIDTH: MEM/WB forwarding source.
- `src_a`, `src_b`, out, WIDTH: ALU operands.
- `ALU_control`, out, 3: registered ALU operation.
- `ex_store_data`, out, WIDTH: forwarded rt value for `sw`.
- `ex_write_reg`, out, RA: destination (rd if reg_dst=1, else rt).
- `ex_valid`, `ex_reg_write`, `ex_mem_to_reg`, `ex_mem_write`, out, 1 each: registered control.
- `hazard_stall`, out, 1: load-use stall request to PC and IF/ID.

## Operation
- Registered state:
  - valid, rs, rt, write_reg, rd1, rd2, imm, alu_control, alu_src.
  - reg_write, mem_to_reg, mem_write.
- Per-edge update priority:
  - 1. `reset`: all state cleared.
  - 2. `stall`: hold all state.
  - 3. `flush`, `hazard_stall`, or `!id_valid`: load a bubble (all state zero).
  - 4. Otherwise capture the ID inputs.
- `flush` together with `stall`: hold wins. The redirect controller keeps `flush` asserted until `stall` drops.
- Capture bypass: on capture, if `memwb_reg_write` is set, `memwb_write_reg` is nonzero and equals `id_rs` (resp. `id_rt`), store `memwb_result` instead of `id_rd1` (resp. `id_rd2`).
- Forwarding for a registered operand, rs or rt, with address r:
  - If `exmem_reg_write`, `exmem_write_reg`==r and r≠0: use `exmem_alu_result`.
  - Else if `memwb_reg_write`, `memwb_write_reg`==r and r≠0: use `memwb_result`.
  - Else: use the registered value.
  - EX/MEM has priority over MEM/WB.
  - Register 0 is never forwarded.
- Operand outputs:
  - `src_a` = forwarded rs.
  - `ex_store_data` = forwarded rt.
  - `src_b` = registered imm if alu_src=1, else forwarded rt.
- `hazard_stall` = ex_valid & ex_mem_to_reg & ex_write_reg≠0 & id_valid & (ex_write_reg==id_rs | ex_write_reg==id_rt).
  - The rt compare is unconditional (conservative).
- Bubble semantics: a bubble drives reg_write=0, mem_write=0 and ALU_control=000. A bubble has no architectural effect.

## Timing
- Latency: one cycle from ID inputs to registered outputs.
- Combinational paths (same cycle, no register):
  - Forwarding inputs → `src_a`, `src_b`, `ex_store_data`.
  - ID inputs → `hazard_stall`.
- `hazard_stall` is high for exactly one cycle per load-use pair.
  - The next edge inserts one bubble.
  - The dependent instruction is then captured. MEM/WB forwarding or the capture bypass supplies the load data.
- Reset values (asynchronous, immediate):
  - `ex_valid`, `ex_reg_write`, `ex_mem_to_reg`, `ex_mem_write` = 0.
  - `ALU_control` = 000.
  - `ex_write_reg` = 0.
  - `src_a`, `src_b`, `ex_store_data` = 0 while no forwarding inputs match.
  - `hazard_stall` = 0.
- Reset mid-stall or mid-flush: state clears at once. The first edge after reset deasserts captures normally.

## Test plan
- Reset with all inputs nonzero → all outputs 0, `ALU_control`=000. Release reset; capture add, rd1=5, rd2=7 → next cycle `src_a`=5, `src_b`=7, `ALU_control`=010.
- EX `add $3`, then ID `sub $4,$3,$3` with `exmem_write_reg`=3, `exmem_alu_result`=0x10 → `src_a`=`src_b`=0x10. With `memwb_write_reg`=3, `memwb_result`=0x20 also matching → still 0x10 (EX/MEM priority).
- `lw $2` in EX, ID `add $5,$2,$1` → `hazard_stall`=1 for one cycle, then a bubble (`ex_reg_write`=0). The dependent instruction then gets `memwb_result` for rs.
- Forwarding target $0 with `exmem_reg_write`=1, `exmem_alu_result`=0xFFFF → `src_a` = registered rd1, not forwarded.
- `stall`=1 for 3 cycles while ID inputs change → outputs unchanged. `stall` and `flush` both high → hold. `flush` alone → `ex_valid`=0, `ex_mem_write`=0.
- ID `ori`-style with alu_src=1, imm=0xFFFFFFF8, `sw` rt forwarded from EX/MEM value 0xAB → `src_b`=0xFFFFFFF8, `ex_store_data`=0xAB.
